// File: rtl/adder_tester_pkg.sv
// Shared types and constants for the adder tester: FSM states, timeout length,
// LFSR tap constants and the error-counter saturation value.
package adder_tester_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StGap,
        StDrain,
        StFin
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES = 64;

    // Galois (right-shift) tap masks for maximal-length sequences
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    localparam logic [15:0] ERR_SAT = 16'hFFFF;

    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return {24'h0, LFSR_TAPS_8};
            32:      return LFSR_TAPS_32;
            default: return {16'h0, LFSR_TAPS_16};
        endcase
    endfunction

endpackage

// File: rtl/adder_tester_if.sv
// Operand/result bus between the tester (master) and the adder under test (slave).
interface adder_tester_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] dinp_a;
    logic [DATA_W-1:0] dinp_b;
    logic              valid_a;
    logic              valid_b;
    logic [DATA_W:0]   out;
    logic              valid_out;

    modport master (
        output dinp_a, dinp_b, valid_a, valid_b,
        input  out, valid_out
    );

    modport slave (
        input  dinp_a, dinp_b, valid_a, valid_b,
        output out, valid_out
    );
endinterface

// File: rtl/adder_tester_exp_fifo.sv
// Expected-sum FIFO: synchronous, first-word-fall-through, with full/empty and occupancy.
module exp_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == (AW + 1)'(DEPTH));
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/adder_tester.sv
// Drives operand pairs into an adder and checks returned sums against a FIFO of expected values.
// Define ADDER_TESTER_LFSR_EN for LFSR operands; otherwise operands are up/down counters.
module adder_tester
    import adder_tester_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          count,
    input  logic [3:0]           gap,
    adder_tester_if.master       bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_cnt
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef ADDER_TESTER_LFSR_EN
    localparam logic [31:0]       TAPS_ALL = lfsr_taps(DATA_W);
    localparam logic [DATA_W-1:0] TAPS     = TAPS_ALL[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SEED_A   = DATA_W'(1);
    localparam logic [DATA_W-1:0] SEED_B   = DATA_W'(2);
`else
    localparam logic [DATA_W-1:0] SEED_A   = '0;
    localparam logic [DATA_W-1:0] SEED_B   = '1;
`endif

    state_e            r_state;
    logic [15:0]       r_remain;
    logic [3:0]        r_gap_cfg;
    logic [3:0]        r_gap_cnt;
    logic [TW-1:0]     r_tmo;
    logic [DATA_W-1:0] r_gen_a;
    logic [DATA_W-1:0] r_gen_b;
    logic [DATA_W-1:0] r_dinp_a;
    logic [DATA_W-1:0] r_dinp_b;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [15:0]       r_err;

    logic              w_start_ok;
    logic              w_issue;
    logic              w_pop;
    logic              w_result_err;
    logic              w_tmo_expire;
    logic              w_drain_done;
    logic              w_flush;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W:0]   w_fifo_data;
    logic [CW-1:0]     w_fifo_cnt;
    logic [DATA_W:0]   w_exp_sum;
    logic [DATA_W-1:0] w_gen_a_nxt;
    logic [DATA_W-1:0] w_gen_b_nxt;
    logic [15:0]       w_err_add;
    logic [16:0]       w_err_sum;
    logic [15:0]       w_err_nxt;

    always_comb begin
        w_start_ok   = start && (r_state == StIdle);
        w_issue      = (r_state == StSend) && !w_fifo_full;
        w_pop        = bus.valid_out && !w_fifo_empty;
        w_result_err = bus.valid_out && (w_fifo_empty || (w_fifo_data != bus.out));
        w_drain_done = (r_state == StDrain)
                       && (w_fifo_empty || (w_pop && (w_fifo_cnt == CW'(1))));
        w_tmo_expire = (r_state == StDrain) && !bus.valid_out && (r_tmo == TMO_LAST);
        w_flush      = w_tmo_expire && !w_drain_done;
        w_exp_sum    = {1'b0, r_gen_a} + {1'b0, r_gen_b};
        // On timeout every entry still queued is a missing result
        w_err_add    = w_flush ? 16'(w_fifo_cnt) : 16'(w_result_err);
        w_err_sum    = {1'b0, (w_start_ok ? 16'h0 : r_err)} + {1'b0, w_err_add};
        w_err_nxt    = w_err_sum[16] ? ERR_SAT : w_err_sum[15:0];
`ifdef ADDER_TESTER_LFSR_EN
        w_gen_a_nxt  = (r_gen_a >> 1) ^ (r_gen_a[0] ? TAPS : '0);
        w_gen_b_nxt  = (r_gen_b >> 1) ^ (r_gen_b[0] ? TAPS : '0);
`else
        w_gen_a_nxt  = r_gen_a + 1'b1;
        w_gen_b_nxt  = r_gen_b - 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_remain  <= '0;
            r_gap_cfg <= '0;
            r_gap_cnt <= '0;
            r_tmo     <= '0;
            r_gen_a   <= SEED_A;
            r_gen_b   <= SEED_B;
            r_dinp_a  <= '0;
            r_dinp_b  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= '0;
        end else begin
            r_valid <= w_issue;
            r_done  <= 1'b0;
            r_err   <= w_err_nxt;
            if (w_issue) begin
                r_dinp_a <= r_gen_a;
                r_dinp_b <= r_gen_b;
                r_gen_a  <= w_gen_a_nxt;
                r_gen_b  <= w_gen_b_nxt;
            end
            case (r_state)
                StIdle: begin
                    if (w_start_ok) begin
                        r_gen_a   <= SEED_A;
                        r_gen_b   <= SEED_B;
                        r_gap_cfg <= gap;
                        r_remain  <= count;
                        r_pass    <= 1'b0;
                        if (count == '0) begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == '0);
                        end else begin
                            r_state <= StSend;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (w_issue) begin
                        r_remain <= r_remain - 1'b1;
                        if (r_remain == 16'd1) begin
                            r_state <= StDrain;
                            r_tmo   <= '0;
                        end else if (r_gap_cfg != '0) begin
                            r_state   <= StGap;
                            r_gap_cnt <= r_gap_cfg;
                        end
                    end
                end
                StGap: begin
                    if (r_gap_cnt == 4'd1) r_state <= StSend;
                    else                   r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                StDrain: begin
                    if (w_drain_done || w_tmo_expire) begin
                        r_state <= StFin;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0);
                    end else if (bus.valid_out) begin
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                StFin:   r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    exp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_exp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_issue),
        .i_data  (w_exp_sum),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    assign bus.dinp_a  = r_dinp_a;
    assign bus.dinp_b  = r_dinp_b;
    assign bus.valid_a = r_valid;
    assign bus.valid_b = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign err_cnt     = r_err;

endmodule

// File: tb/tb_adder_tester.sv
// Bench for adder_tester: a behavioural adder with configurable latency, corruption and
// dropping; expected operand sequence and error counts come from the bench's own model.
module tb_adder_tester;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] count;
    logic [3:0]  gap;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_cnt;

    adder_tester_if #(.DATA_W(16)) bus ();

    adder_tester #(
        .DATA_W     (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .count   (count),
        .gap     (gap),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // adder knobs (written by the stimulus process only)
    int lat          = 2;
    int corrupt_nth  = -1;
    bit drop_all     = 1'b0;
    bit rand_corrupt = 1'b0;

    // model state (written by the adder/monitor process only)
    int          cyc = 0;
    int          idx, n_iss, n_ret, max_outst, n_corrupt, op_bad = 0, n_done = 0;
    int          first_v, prev_v, last_v;
    logic [15:0] ref_a, ref_b;
    bit          sched_v [64];
    logic [16:0] sched_d [64];

    int start_cyc, done_cyc;
    bit got_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

`ifdef ADDER_TESTER_LFSR_EN
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction
`endif

    // Adder and operand monitor; everything sampled mid-cycle on the falling edge
    always @(negedge clk) begin
        logic [16:0] s;
        cyc = cyc + 1;
        if (start) begin
`ifdef ADDER_TESTER_LFSR_EN
            ref_a = 16'h0001; ref_b = 16'h0002;
`else
            ref_a = 16'h0000; ref_b = 16'hFFFF;
`endif
            idx = 0; n_iss = 0; n_ret = 0; max_outst = 0; n_corrupt = 0;
            first_v = -1; prev_v = -1; last_v = -1;
        end
        if (bus.valid_a || bus.valid_b) begin
            if (bus.valid_a !== bus.valid_b || bus.dinp_a !== ref_a || bus.dinp_b !== ref_b)
                op_bad++;
`ifdef ADDER_TESTER_LFSR_EN
            ref_a = lfsr_step(ref_a); ref_b = lfsr_step(ref_b);
`else
            ref_a = ref_a + 16'd1; ref_b = ref_b - 16'd1;
`endif
            n_iss++;
            if (first_v < 0) first_v = cyc;
            prev_v = last_v;
            last_v = cyc;
            s = {1'b0, bus.dinp_a} + {1'b0, bus.dinp_b};
            if (drop_all) begin
                n_corrupt++;
            end else begin
                if (idx == corrupt_nth || (rand_corrupt && $urandom_range(0, 5) == 0)) begin
                    s = s ^ 17'd1;
                    n_corrupt++;
                end
                sched_v[(cyc + lat) % 64] = 1'b1;
                sched_d[(cyc + lat) % 64] = s;
            end
            idx++;
        end
        if (n_iss - n_ret > max_outst) max_outst = n_iss - n_ret;
        bus.valid_out = sched_v[cyc % 64];
        bus.out       = sched_d[cyc % 64];
        if (sched_v[cyc % 64]) n_ret++;
        sched_v[cyc % 64] = 1'b0;
        if (done) n_done++;
    end

    task automatic run(input int cnt, input int gp, input string tag);
        repeat (2) @(negedge clk);
        #1;
        count = 16'(cnt);
        gap   = 4'(gp);
        start = 1'b1;
        start_cyc = cyc;
        got_done  = 1'b0;
        for (int i = 0; i < 3000 && !got_done; i++) begin
            @(negedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
        end
        check({tag, "_done_seen"}, 32'(got_done), 1);
        if (got_done) begin
            check({tag, "_err_cnt"}, err_cnt, n_corrupt);
            check({tag, "_pass"}, pass, (n_corrupt == 0) ? 1 : 0);
            check({tag, "_busy_at_done"}, busy, 0);
        end
        check({tag, "_operands"}, op_bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; count = '0; gap = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_valid_a", bus.valid_a, 0);
        check("rst_valid_b", bus.valid_b, 0);
        check("rst_dinp_a", bus.dinp_a, 0);
        check("rst_dinp_b", bus.dinp_b, 0);
        rst = 1'b0;

        run(5, 0, "loop");
        check("loop_span", last_v - first_v, 4);
        check("loop_issued", n_iss, 5);
        repeat (5) @(negedge clk);
        #1;
        check("loop_pass_held", pass, 1);
        check("loop_idle", busy, 0);

        corrupt_nth = 2;
        run(10, 0, "corrupt");
        corrupt_nth = -1;

        lat = 12;
        run(20, 0, "stall");
        check("stall_outstanding", max_outst, 8);
        check("stall_issued", n_iss, 20);
        lat = 2;

        drop_all = 1'b1;
        run(3, 0, "timeout");
        check("timeout_delay", done_cyc - last_v, 64);
        drop_all = 1'b0;

        run(2, 3, "gap");
        check("gap_spacing", last_v - prev_v, 4);

        run(0, 0, "zero");
        check("zero_latency", done_cyc - start_cyc, 1);

        // abort a run with reset; in-flight sums arrive afterwards as unexpected results
        repeat (2) @(negedge clk);
        #1;
        count = 16'd20; gap = 4'd0; start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        check("abort_err", err_cnt, 0);
        check("abort_valid_a", bus.valid_a, 0);
        check("abort_valid_b", bus.valid_b, 0);
        check("abort_dinp_a", bus.dinp_a, 0);
        check("abort_dinp_b", bus.dinp_b, 0);
        rst = 1'b0;
        begin
            int nd;
            nd = n_done;
            repeat (40) @(negedge clk);
            #1;
            check("abort_no_done", n_done, nd);
        end
        check("abort_stray_results", err_cnt, 2);
        run(5, 0, "after_abort");

        rand_corrupt = 1'b1;
        for (int r = 0; r < 6; r++) begin
            lat = $urandom_range(1, 14);
            run($urandom_range(1, 24), $urandom_range(0, 3), $sformatf("rand%0d", r));
            check($sformatf("rand%0d_outstanding", r), 32'(max_outst <= 8), 1);
        end
        rand_corrupt = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_tester.md
ADDER_TESTER -- requirements
Module: adder_tester

Interface
- REQ-001 Parameter DATA_W, default 16, operand width, matching the project-wide data width setting.
- REQ-002 Parameter FIFO_DEPTH, default 8, power of two; the number of sums that may be outstanding at once.
- REQ-003 clk  in  1  sole clock; all logic rising-edge.
- REQ-004 rst  in  1  reset, synchronous, active-high.
- REQ-005 start  in  1  single-cycle pulse that begins a run; ignored while busy.
- REQ-006 count  in  16  number of operand pairs in the run; sampled on start.
- REQ-007 gap  in  4  idle cycles inserted after each issued pair; sampled on start.
- REQ-008 dinp_a / dinp_b  out  DATA_W  operands driven to the adder.
- REQ-009 valid_a / valid_b  out  1  operand qualifiers; always asserted together.
- REQ-010 out  in  DATA_W+1  sum returned by the adder.
- REQ-011 valid_out  in  1  sum qualifier.
- REQ-012 busy  out  1  run in progress.
- REQ-013 done  out  1  one-cycle pulse at the end of a run.
- REQ-014 pass  out  1  result of the last run; held until the next start.
- REQ-015 err_cnt  out  16  errors in the current run; saturates at 0xFFFF.

Function
- REQ-016 FSM states: IDLE, SEND, GAP, DRAIN, FIN.
- REQ-017 Transitions:
  - IDLE->SEND on start with count!=0.
  - IDLE->FIN on start with count==0.
  - SEND->GAP after a pair is issued, when gap!=0 and pairs remain.
  - SEND->DRAIN after the last pair is issued.
  - GAP->SEND after gap idle cycles.
  - DRAIN->FIN when the FIFO is empty or on timeout.
  - FIN->IDLE after 1 cycle.
- REQ-018 In SEND, one pair is issued per cycle (valid_a=valid_b=1) only when the FIFO is not full; otherwise it stalls with valids low.
- REQ-019 Each issued pair pushes the expected sum a+b, computed at DATA_W+1 bits with no truncation, into the FIFO in the same cycle.
- REQ-020 Each valid_out pops the FIFO and compares the popped value with out; a mismatch increments err_cnt.
- REQ-021 valid_out with the FIFO empty (unexpected result) increments err_cnt; there is no pop.
- REQ-022 A simultaneous push and pop in the same cycle is legal, and FIFO occupancy is unchanged.
- REQ-023 Results are accepted in any state, including IDLE; a result in IDLE with an empty FIFO counts as an error.
- REQ-024 In DRAIN, a 64-cycle timeout counter is reset by each valid_out; on expiry, each remaining FIFO entry adds 1 to err_cnt (saturating), the FIFO is flushed, and the FSM goes to FIN.
- REQ-025 In FIN: done=1; pass=(err_cnt==0), or (err_cnt==0 after the final update in that cycle).
- REQ-026 busy=1 in SEND, GAP and DRAIN.
- REQ-027 start clears err_cnt and pass.
- REQ-028 When valids are low, dinp_a and dinp_b hold their last value.

Reset
- REQ-029 While rst=1:
  - FSM goes to IDLE; FIFO is emptied; counters are cleared.
  - dinp_a, dinp_b, valid_a, valid_b, busy, done, pass and err_cnt are 0.
- REQ-030 rst mid-run aborts the run with no done pulse; results arriving after rst count as unexpected.

Configuration
- REQ-031 Macro ADDER_TESTER_LFSR_EN:
  - Defined: operands come from two maximal-length Galois LFSRs, seeds A=1 and B=2, each stepping once per issued pair.
  - Undefined: dinp_a counts up from 0 and dinp_b counts down from all-ones, each stepping once per issued pair, wrapping modulo 2^DATA_W.

Structure
- REQ-032 Package adder_tester_pkg holds:
  - the state enum;
  - TIMEOUT_CYCLES=64;
  - the LFSR tap constants for DATA_W 8/16/32;
  - ERR_SAT=16'hFFFF.
- REQ-033 Sub-module exp_fifo: synchronous, depth FIFO_DEPTH, width DATA_W+1, with full/empty flags and first-word-fall-through read.

Verification
- REQ-034 Loopback adder with latency 2, counter mode, count=5, gap=0: operand pairs (0,FFFF),(1,FFFE)... appear on 5 consecutive cycles; done fires; pass=1; err_cnt=0.
- REQ-035 Adder that corrupts the 3rd sum, count=10: err_cnt=1 and pass=0 at done.
- REQ-036 Adder latency 12, count=20, FIFO_DEPTH=8: issuing stalls after 8 outstanding pairs; no errors; pass=1.
- REQ-037 Adder that never responds, count=3: done arrives 64 cycles after the last issue, with err_cnt=3 and pass=0.
- REQ-038 gap=3, count=2: the two valid pulses are exactly 4 cycles apart; start with count=0 gives done 1 cycle later with pass=1.
- REQ-039 rst asserted mid-SEND: all outputs are 0 the next cycle; there is no done; a later start runs cleanly with pass=1.
